// File: rtl/mult_div_unit.sv
// Multicycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle on shared registers.
module mult_div_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state;
  logic        op_div;
  logic        neg_res;
  logic        neg_rem;
  logic [4:0]  count;
  // acc_hi/acc_lo: product for multiply, {remainder, quotient} for divide
  logic [31:0] acc_hi;
  logic [31:0] acc_lo;
  logic [31:0] opnd;

  logic        in_signed;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] mul_sum;
  logic [32:0] rem_sh;
  logic        fits;
  logic [31:0] rem_sub;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  always_comb begin
    in_signed = ~op[0];
    a_mag     = (in_signed && a[31]) ? (~a + 32'd1) : a;
    b_mag     = (in_signed && b[31]) ? (~b + 32'd1) : b;

    mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : 32'd0)};

    rem_sh    = {acc_hi, acc_lo[31]};
    fits      = (rem_sh >= {1'b0, opnd});
    rem_sub   = rem_sh[31:0] - opnd;

    prod_fix  = neg_res ? (~{acc_hi, acc_lo} + 64'd1) : {acc_hi, acc_lo};
    quo_fix   = neg_res ? (~acc_lo + 32'd1) : acc_lo;
    rem_fix   = neg_rem ? (~acc_hi + 32'd1) : acc_hi;
  end

  assign busy = (state == S_CALC) || (state == S_FIX);
  assign done = (state == S_DONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      op_div      <= 1'b0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      count       <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      opnd        <= '0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_div      <= op[1];
            count       <= '0;
            acc_hi      <= '0;
            neg_res     <= in_signed && (a[31] ^ b[31]);
            neg_rem     <= in_signed && op[1] && a[31];
            div_by_zero <= op[1] && (b == 32'd0);
            if (op[1]) begin
              acc_lo <= a_mag;
              opnd   <= b_mag;
            end else begin
              acc_lo <= b_mag;
              opnd   <= a_mag;
            end
            state <= (op[1] && (b == 32'd0)) ? S_DONE : S_CALC;
          end
        end
        S_CALC: begin
          if (op_div) begin
            acc_hi <= fits ? rem_sub : rem_sh[31:0];
            acc_lo <= {acc_lo[30:0], fits};
          end else begin
            {acc_hi, acc_lo} <= {mul_sum, acc_lo[31:1]};
          end
          count <= count + 5'd1;
          if (count == 5'd31) state <= S_FIX;
        end
        S_FIX: begin
          if (op_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
          state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: hand-computed results and cycle-accurate
// busy/done windows checked with immediate assertions.
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_chk  = 0;
  int n_fail = 0;

  int done_at, done_cnt, busy_first, busy_last, overlap;

  mult_div_unit dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  // Issue one op, then observe 70 cycles. Index k is the cycle between
  // edges E0+k-1 and E0+k. p1/p2 inject a DIVU 9/3 start, rst_at a reset.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int p1, input int p2, input int rst_at);
    done_at = 0; done_cnt = 0; busy_first = 0; busy_last = 0; overlap = 0;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clock); #1;
    start = 1'b0; op = ~o; a = 32'h1234_5678; b = 32'd0;
    for (int k = 1; k <= 70; k++) begin
      if (done) begin
        done_cnt++;
        if (done_at == 0) done_at = k;
      end
      if (busy) begin
        if (busy_first == 0) busy_first = k;
        busy_last = k;
      end
      if (busy && done) overlap++;
      start = 1'b0;
      reset = 1'b0;
      if (k == p1 || k == p2) begin
        start = 1'b1; op = 2'b11; a = 32'd9; b = 32'd3;
      end
      if (k == rst_at) reset = 1'b1;
      @(posedge clock); #1;
    end
    start = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_dbz", {31'd0, div_by_zero}, 32'd0);

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
    chk("multu_done_at", done_at, 34);
    chk("multu_done_cnt", done_cnt, 1);
    chk("multu_busy_first", busy_first, 1);
    chk("multu_busy_last", busy_last, 33);
    chk("multu_overlap", overlap, 0);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);

    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 0, 0, 0);
    chk("mult_neg_hi", hi, 32'hFFFF_FFFF);
    chk("mult_neg_lo", lo, 32'hFFFF_FFEB);

    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0, 0);
    chk("div_neg_lo", lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", hi, 32'hFFFF_FFFF);

    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
    chk("div_ovf_lo", lo, 32'h8000_0000);
    chk("div_ovf_hi", hi, 32'h0);
    chk("div_ovf_dbz", {31'd0, div_by_zero}, 32'd0);

    run_op(2'b11, 32'd100, 32'd7, 0, 0, 0);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);
    chk("divu_done_at", done_at, 34);

    run_op(2'b10, 32'd5, 32'd0, 0, 0, 0);
    chk("dbz_done_at", done_at, 1);
    chk("dbz_done_cnt", done_cnt, 1);
    chk("dbz_busy_first", busy_first, 0);
    chk("dbz_flag", {31'd0, div_by_zero}, 32'd1);
    chk("dbz_hi", hi, 32'd2);
    chk("dbz_lo", lo, 32'd14);

    run_op(2'b01, 32'd3, 32'd5, 10, 34, 0);
    chk("ign_dbz_clr", {31'd0, div_by_zero}, 32'd0);
    chk("ign_hi", hi, 32'd0);
    chk("ign_lo", lo, 32'd15);
    chk("ign_done_cnt", done_cnt, 1);
    chk("ign_done_at", done_at, 34);

    run_op(2'b00, 32'd6, 32'd7, 0, 0, 12);
    chk("rst_done_cnt", done_cnt, 0);
    chk("rst_busy_last", busy_last, 12);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);

    run_op(2'b01, 32'd6, 32'd7, 0, 0, 0);
    chk("post_rst_lo", lo, 32'd42);
    chk("post_rst_hi", hi, 32'd0);
    chk("post_rst_done_at", done_at, 34);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
